// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a two-entry (OUT + SKID) output
// buffer so that one result per cycle is sustained under back-pressure.
// Optional CSR zimm format (fmt 111) is enabled by defining IMM_GEN_ZIMM_EN;
// without it fmt 111 is reported through out_err with a zero immediate.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_fmt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam logic [2:0] FMT_I     = 3'b001;
   localparam logic [2:0] FMT_S     = 3'b010;
   localparam logic [2:0] FMT_U     = 3'b011;
   localparam logic [2:0] FMT_SHAMT = 3'b100;
   localparam logic [2:0] FMT_B     = 3'b101;
   localparam logic [2:0] FMT_J     = 3'b110;
   localparam logic [2:0] FMT_Z     = 3'b111;

   // Signed formats are assembled as a 32-bit signed value and widened with a
   // signed cast, which sign-extends to XLEN for the 64-bit build.
   function automatic logic [XLEN-1:0] dec_imm(input logic [31:0] instr,
                                               input logic [2:0]  fmt);
      logic signed [31:0] simm;
      logic [5:0]         sh;
      logic [XLEN-1:0]    r;
      simm = '0;
      r    = '0;
      sh   = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
      case (fmt)
         FMT_I: begin
            simm = {{20{instr[31]}}, instr[31:20]};
            r    = XLEN'(simm);
         end
         FMT_S: begin
            simm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            r    = XLEN'(simm);
         end
         FMT_U: begin
            simm = {instr[31:12], 12'b0};
            r    = XLEN'(simm);
         end
         FMT_B: begin
            simm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            r    = XLEN'(simm);
         end
         FMT_J: begin
            simm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            r    = XLEN'(simm);
         end
         FMT_SHAMT: r = XLEN'(sh);
`ifdef IMM_GEN_ZIMM_EN
         FMT_Z:     r = XLEN'(instr[19:15]);
`endif
         default:   r = '0;
      endcase
      return r;
   endfunction

   // Only the zimm format can be illegal, and only when it is not built in.
   function automatic logic dec_err(input logic [2:0] fmt);
`ifdef IMM_GEN_ZIMM_EN
      dec_err = 1'b0 & fmt[0];
`else
      dec_err = (fmt == FMT_Z);
`endif
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;
   logic             out_err_q,   out_err_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
   logic             skid_err_q,   skid_err_d;

   logic             accept;
   logic             pop;
   logic [XLEN-1:0]  new_imm;
   logic             new_err;
   logic             unused_opcode;

   // The opcode field never contributes to any immediate.
   assign unused_opcode = ^in_instr[6:0];

   assign in_ready  = rst_n & ~skid_valid_q;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid_q & out_ready;
   assign new_imm   = dec_imm(in_instr, in_fmt);
   assign new_err   = dec_err(in_fmt);

   assign out_valid = out_valid_q;
   assign out_imm   = out_imm_q;
   assign out_tag   = out_tag_q;
   assign out_err   = out_err_q;

   // Next-state for the OUT/SKID pair: FIFO order, SKID refills OUT on pop.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_tag_d    = out_tag_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_tag_d   = skid_tag_q;
      skid_err_d   = skid_err_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (pop && skid_valid_q) begin
         out_valid_d = 1'b1;
         out_imm_d   = skid_imm_q;
         out_tag_d   = skid_tag_q;
         out_err_d   = skid_err_q;
         if (accept) begin
            skid_imm_d = new_imm;
            skid_tag_d = in_tag;
            skid_err_d = new_err;
         end else begin
            skid_valid_d = 1'b0;
         end
      end else if (accept && (!out_valid_q || pop)) begin
         out_valid_d = 1'b1;
         out_imm_d   = new_imm;
         out_tag_d   = in_tag;
         out_err_d   = new_err;
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = new_imm;
         skid_tag_d   = in_tag;
         skid_err_d   = new_err;
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset clears both entries including their payload.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_tag_q    <= '0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_tag_q   <= '0;
         skid_err_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_tag_q    <= out_tag_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_tag_q   <= skid_tag_d;
         skid_err_q   <= skid_err_d;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus
// stream and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [2:0]  in_fmt = '0;
   logic [4:0]  in_tag = '0;
   logic        out_ready = 1'b0;

   logic        in_ready32, out_valid32, out_err32;
   logic [31:0] out_imm32;
   logic [4:0]  out_tag32;
   logic        in_ready64, out_valid64, out_err64;
   logic [63:0] out_imm64;
   logic [4:0]  out_tag64;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready32), .in_instr(in_instr), .in_fmt(in_fmt),
      .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32));

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready64), .in_instr(in_instr), .in_fmt(in_fmt),
      .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64));

   typedef struct {
      logic [63:0] imm64;
      logic [31:0] imm32;
      logic [4:0]  tag;
      logic        err;
   } ent_t;

   ent_t       q[$];
   logic [4:0] got[$];
   logic       acc_m;
   int         checks = 0;
   int         errors = 0;

   // Reference immediate from the format rules, using shifts on a 64-bit signed word.
   function automatic ent_t ref_ent(logic [31:0] ins, logic [2:0] f, logic [4:0] t);
      ent_t   e;
      longint s;
      longint v;
      s = longint'($signed(ins));
      v = 0;
      e.err = 1'b0;
      e.tag = t;
      case (f)
         3'd1: v = s >>> 20;
         3'd2: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
         3'd3: v = (s >>> 12) <<< 12;
         3'd5: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                   (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         3'd6: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                   (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
`ifdef IMM_GEN_ZIMM_EN
         3'd7: v = longint'(ins[19:15]);
`else
         3'd7: e.err = 1'b1;
`endif
         default: v = 0;
      endcase
      e.imm64 = v;
      e.imm32 = v[31:0];
      if (f == 3'd4) begin
         e.imm64 = 64'(ins[25:20]);
         e.imm32 = 32'(ins[24:20]);
      end
      return e;
   endfunction

   // Drive one cycle, advance the model, then wait until just after the edge.
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [2:0] f,
                      input logic [4:0] t, input logic ordy, input logic fl,
                      input logic rn);
      logic pop;
      in_valid = v; in_instr = ins; in_fmt = f; in_tag = t;
      out_ready = ordy; flush = fl; rst_n = rn;
      #1;
      if (out_valid32 && ordy && rn && !fl) got.push_back(out_tag32);
      acc_m = 1'b0;
      if (!rn || fl) begin
         q.delete();
      end else begin
         pop   = (q.size() > 0) && ordy;
         acc_m = v && (q.size() < 2);
         if (pop) void'(q.pop_front());
         if (acc_m) q.push_back(ref_ent(ins, f, t));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cyc(1'b1, 32'hFFF00093, 3'd1, 5'd1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'hFFF00093, 3'd1, 5'd2, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({out_valid32, out_imm32, out_tag32, out_err32, in_ready32} !== 40'd0) begin
         errors++;
         $display("FAIL reset32 got v=%b imm=%h tag=%h err=%b rdy=%b want all 0",
                  out_valid32, out_imm32, out_tag32, out_err32, in_ready32);
      end
      checks++;
      if ({out_valid64, out_imm64, out_tag64, out_err64, in_ready64} !== 72'd0) begin
         errors++;
         $display("FAIL reset64 got v=%b imm=%h tag=%h err=%b rdy=%b want all 0",
                  out_valid64, out_imm64, out_tag64, out_err64, in_ready64);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({in_ready32, in_ready64} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_ready got %b%b want 11", in_ready32, in_ready64);
      end
   endtask

   task automatic test_formats();
      logic [31:0] ins [5] = '{32'hFFF00093, 32'h123450B7, 32'hFE000EE3, 32'h0080006F, 32'h03F0D093};
      logic [2:0]  fm  [5] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd4};
      logic [31:0] e32 [5] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h8, 32'h1F};
      logic [63:0] e64 [5] = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h3F};
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, ins[i], fm[i], 5'(i + 1), 1'b1, 1'b0, 1'b1);
         checks++;
         if ({out_valid32, out_imm32, out_err32, out_valid64, out_imm64, out_err64} !==
             {1'b1, e32[i], 1'b0, 1'b1, e64[i], 1'b0}) begin
            errors++;
            $display("FAIL fmt_%0d got v=%b imm32=%h err=%b v=%b imm64=%h err=%b want 1 %h 0 1 %h 0",
                     i, out_valid32, out_imm32, out_err32, out_valid64, out_imm64, out_err64,
                     e32[i], e64[i]);
         end
      end
      cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic ev, er;
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
             5'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0), 1'b1);
         ev = (q.size() > 0);
         er = (q.size() < 2);
         checks++;
         if ({out_valid32, in_ready32, out_valid64, in_ready64} !== {ev, er, ev, er}) begin
            errors++;
            $display("FAIL rand_hs cyc %0d got v/r32=%b%b v/r64=%b%b want %b%b",
                     i, out_valid32, in_ready32, out_valid64, in_ready64, ev, er);
         end
         if (ev) begin
            checks++;
            if ({out_imm32, out_tag32, out_err32, out_imm64, out_tag64, out_err64} !==
                {q[0].imm32, q[0].tag, q[0].err, q[0].imm64, q[0].tag, q[0].err}) begin
               errors++;
               $display("FAIL rand_data cyc %0d got %h/%h/%b %h/%h/%b want %h/%h/%b %h",
                        i, out_imm32, out_tag32, out_err32, out_imm64, out_tag64, out_err64,
                        q[0].imm32, q[0].tag, q[0].err, q[0].imm64);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int         nt;
      logic       saw_block;
      logic       ev, er;
      cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      got.delete();
      nt = 1;
      saw_block = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         cyc((nt <= 4), $urandom, 3'd1, 5'(nt), !(c == 2 || c == 3), 1'b0, 1'b1);
         if (acc_m) nt++;
         if (!in_ready32) saw_block = 1'b1;
         ev = (q.size() > 0);
         er = (q.size() < 2);
         checks++;
         if ({out_valid32, in_ready32, out_valid64, in_ready64} !== {ev, er, ev, er} ||
             (ev && out_tag32 !== q[0].tag)) begin
            errors++;
            $display("FAIL bp_cyc%0d got v/r=%b%b tag=%h want %b%b", c,
                     out_valid32, in_ready32, out_tag32, ev, er);
         end
      end
      checks++;
      if (!saw_block) begin
         errors++;
         $display("FAIL bp_in_ready_drop got never-low want low once");
      end
      checks++;
      if (got.size() != 4 || got[0] !== 5'd1 || got[1] !== 5'd2 ||
          got[2] !== 5'd3 || got[3] !== 5'd4) begin
         errors++;
         $display("FAIL bp_order got %0d tags (%p) want 1,2,3,4", got.size(), got);
      end
   endtask

   task automatic test_flush();
      cyc(1'b1, 32'hFFF00093, 3'd1, 5'd7, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h123450B7, 3'd3, 5'd8, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({out_valid32, in_ready32, out_valid64, in_ready64} !== 4'b1010) begin
         errors++;
         $display("FAIL flush_fill got %b%b%b%b want 1010",
                  out_valid32, in_ready32, out_valid64, in_ready64);
      end
      cyc(1'b1, 32'hFE000EE3, 3'd5, 5'd9, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({out_valid32, in_ready32, out_valid64, in_ready64} !== 4'b0101) begin
         errors++;
         $display("FAIL flush_clear got %b%b%b%b want 0101",
                  out_valid32, in_ready32, out_valid64, in_ready64);
      end
      got.delete();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
         checks++;
         if ({out_valid32, out_valid64} !== 2'b00) begin
            errors++;
            $display("FAIL flush_stay_empty got %b%b want 00", out_valid32, out_valid64);
         end
      end
      checks++;
      if (got.size() != 0) begin
         errors++;
         $display("FAIL flush_no_tags got %0d popped want 0", got.size());
      end
   endtask

   task automatic test_zimm();
      logic [31:0] w32;
      logic        werr;
`ifdef IMM_GEN_ZIMM_EN
      w32 = 32'h5; werr = 1'b0;
`else
      w32 = 32'h0; werr = 1'b1;
`endif
      cyc(1'b1, 32'h3402D073, 3'd7, 5'd3, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({out_valid32, out_imm32, out_err32, out_tag32} !== {1'b1, w32, werr, 5'd3} ||
          {out_valid64, out_imm64, out_err64} !== {1'b1, 64'(w32), werr}) begin
         errors++;
         $display("FAIL zimm got %h/%b %h/%b want %h/%b", out_imm32, out_err32,
                  out_imm64, out_err64, w32, werr);
      end
      cyc(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 32'hFFF00093, 3'd1, 5'd11, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'hFE000EE3, 3'd5, 5'd12, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 32'h0080006F, 3'd6, 5'd13, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({out_valid32, out_imm32, out_tag32, out_err32, in_ready32,
           out_valid64, out_imm64, out_tag64, out_err64, in_ready64} !== 112'd0) begin
         errors++;
         $display("FAIL reset_mid got %b %h %h %b %b / %b %h %h %b %b want all 0",
                  out_valid32, out_imm32, out_tag32, out_err32, in_ready32,
                  out_valid64, out_imm64, out_tag64, out_err64, in_ready64);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      #1;
      checks++;
      if ({in_ready32, in_ready64} !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid_release got %b%b want 11", in_ready32, in_ready64);
      end
      cyc(1'b1, 32'h123450B7, 3'd3, 5'd14, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({out_valid32, out_imm32, out_tag32} !== {1'b1, 32'h12345000, 5'd14}) begin
         errors++;
         $display("FAIL reset_mid_resume got %b %h %h want 1 12345000 0e",
                  out_valid32, out_imm32, out_tag32);
      end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_back_to_back();
      test_flush();
      test_zimm();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, handshaked immediate generator for the RISC-V decode stage. Extracts and sign-extends the immediate of every base-ISA format (I, S, B, U, J, shift-amount, and optionally CSR zimm) from a 32-bit instruction word to XLEN bits. A two-entry skid buffer sustains one result per cycle under output back-pressure. Sits between instruction decode and the execute-stage operand mux.

## Interface
- XLEN, 32: result width; legal values 32 or 64.
- TAG_W, 5: width of the sideband tag (e.g. rd/ROB index) carried with each instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered entries this cycle.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word.
- in_fmt  in  3  format select: 000 none, 001 I, 010 S, 011 U, 100 SHAMT, 101 B, 110 J, 111 Z.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_imm  out  XLEN  generated immediate.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  in_fmt was illegal for this build; out_imm is 0.

## Operation
- Formats (s = in_instr[31], sign-extended to XLEN):
  - none: 0. I: {s.., instr[31:20]}. S: {s.., instr[31:25], instr[11:7]}.
  - B: {s.., instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {s.., instr[31:12], 12'b0}. J: {s.., instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SHAMT: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - Z: zero-extended instr[19:15] (see Configuration).
- Storage: output register (OUT) plus skid register (SKID), each with its own valid bit, imm, tag and err.
- Accept = in_valid & in_ready. On accept, decoded result goes to OUT if OUT is empty or popping this cycle (out_valid & out_ready); otherwise to SKID.
- Pop with SKID valid: SKID moves to OUT; simultaneous accept then writes SKID.
- in_ready = rst_n & ~SKID.valid. Order is strictly FIFO.
- flush: OUT.valid and SKID.valid cleared; any accept in the same cycle is discarded. Data fields hold.
- out_err results travel the pipeline like normal results; no retry or drop.

## Timing
- Latency 1: accept at edge N -> out_valid high after edge N.
- Throughput 1/cycle with out_ready held high; SKID never fills.
- out_ready low for one cycle while streaming: SKID fills, in_ready drops the next cycle; with out_ready high again, SKID drains to OUT and in_ready returns after one more edge.
- Both full: in_ready 0, in_valid ignored, outputs hold stable until popped.
- Reset (rst_n low at edge): out_valid 0, out_imm 0, out_tag 0, out_err 0, SKID cleared; in_ready 0 while rst_n low, 1 on the first cycle after release. Reset overrides flush and handshakes, including mid-stream.
- out_* are registered; in_ready depends only on registered state and rst_n.

## Configuration
- IMM_GEN_ZIMM_EN defined: fmt 111 legal, yields zero-extended CSR zimm instr[19:15].
- Undefined: fmt 111 illegal, out_imm 0, out_err 1; no Z logic synthesised.

## Test plan
- XLEN=32, stream I instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> out_imm 0xFFFFFFFF next cycle, out_err 0; then U 0x123450B7 -> 0x12345000.
- XLEN=64, B 0xFE000EE3 -> 0xFFFFFFFFFFFFFFFC; J 0x0080006F -> 0x0000000000000008; SHAMT 0x03F0D093 -> 0x3F.
- Back-pressure: 4 back-to-back tags 1..4, out_ready low cycles 2-3 -> in_ready low after SKID fills, outputs in order 1,2,3,4, none lost or duplicated.
- flush asserted with OUT and SKID full and in_valid high -> out_valid 0 next cycle, in_ready 1, flushed tags never appear.
- fmt 111, instr 0x3402D073: with IMM_GEN_ZIMM_EN out_imm 0x5, out_err 0; without, out_imm 0, out_err 1.
- rst_n low for one cycle mid-stream with both entries full -> all outputs 0, in_ready 0 during reset, 1 the cycle after.
